// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter/sequencer sharing one UART transmitter
//               between N_REQ byte requesters. The winner's byte is captured,
//               a one-cycle start pulse is sent to the transmitter, and the
//               block waits for the transmitter's finish interrupt (or a
//               watchdog timeout) before returning a one-cycle ack.
// Ports       : clk        - system clock
//               rst_n      - synchronous reset, active-high despite the name
//               r_tx_en    - transmit enable; 0 blocks new grants
//               req        - per-requester request level
//               req_data   - byte of requester i on bits [8i+7:8i]
//               ack        - one-cycle completion pulse to the winner
//               ack_err    - qualifies ack; 1 = watchdog timeout
//               busy       - high whenever not idle
//               gnt_id     - index of the current or last granted requester
//               tx_data    - byte to transmitter, stable START..DONE
//               tx_start   - one-cycle start pulse to transmitter
//               tx_finish  - transmitter finish interrupt (level or pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int CNT_W       = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 r_tx_en,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic                 ack_err,
    output logic                 busy,
    output logic [2:0]           gnt_id,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_finish
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // The watchdog is cleared in START and incremented on every WAIT cycle;
    // the WAIT cycle whose incremented count reaches this value is the last
    // one, so DONE lands exactly TIMEOUT_CYC cycles after START.
    localparam logic [CNT_W-1:0] c_wdog_last = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [2:0]       r_ptr;
    logic [2:0]       r_gnt_id;
    logic [7:0]       r_tx_data;
    logic [CNT_W-1:0] r_wdog;
    logic             r_err;

    logic             w_grant;
    logic [2:0]       w_sel;
    logic [7:0]       w_sel_data;
    logic [N_REQ-1:0] w_upper;
    logic [2:0]       w_sel_upper;
    logic [2:0]       w_sel_any;
    logic [CNT_W-1:0] w_wdog_inc;
    logic             w_timeout;

    // ------------------------------------------------------------------
    // Round-robin select: lowest set request at or above the pointer,
    // otherwise wrap to the lowest set request overall.
    // ------------------------------------------------------------------
    always_comb begin
        w_upper     = '0;
        w_sel_upper = 3'd0;
        w_sel_any   = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            w_upper[i] = req[i] && (3'(i) >= r_ptr);
        end
        // Scan downward so the lowest index is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_upper[i]) w_sel_upper = 3'(i);
            if (req[i])     w_sel_any   = 3'(i);
        end
        w_sel = (|w_upper) ? w_sel_upper : w_sel_any;
    end

    always_comb begin
        w_sel_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == w_sel) w_sel_data = req_data[8*i +: 8];
        end
    end

    assign w_grant    = r_tx_en && (|req);
    assign w_wdog_inc = r_wdog + 1'b1;
    assign w_timeout  = (w_wdog_inc == c_wdog_last);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_next = S_START;
            S_START: w_state_next = S_WAIT;
            // Completion takes priority over the watchdog's final cycle.
            S_WAIT:  if (tx_finish || w_timeout) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'd0;
            r_gnt_id  <= 3'd0;
            r_tx_data <= 8'h00;
            r_wdog    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gnt_id  <= w_sel;
                        r_tx_data <= w_sel_data;
                    end
                end
                S_START: r_wdog <= '0;
                S_WAIT: begin
                    r_wdog <= w_wdog_inc;
                    // Only consulted after leaving WAIT, where it is 0 on
                    // completion and 1 on a pure timeout.
                    r_err  <= ~tx_finish;
                end
                S_DONE: begin
                    r_ptr <= (r_gnt_id == 3'(N_REQ - 1)) ? 3'd0 : r_gnt_id + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the registered state
    // ------------------------------------------------------------------
    always_comb begin
        ack = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack[i] = (r_state == S_DONE) && (r_gnt_id == 3'(i));
        end
    end

    assign ack_err  = (r_state == S_DONE) && r_err;
    assign busy     = (r_state != S_IDLE);
    assign tx_start = (r_state == S_START);
    assign gnt_id   = r_gnt_id;
    assign tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with a
//               short watchdog (TIMEOUT_CYC = 100).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N_REQ       = 4;
    localparam int TIMEOUT_CYC = 100;
    localparam int CNT_W       = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 r_tx_en;
    logic [N_REQ-1:0]     req;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     ack;
    logic                 ack_err;
    logic                 busy;
    logic [2:0]           gnt_id;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_finish;

    int vectors;
    int miscompares;

    uart_tx_arbiter #(
        .N_REQ       (N_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r_tx_en   (r_tx_en),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .ack_err   (ack_err),
        .busy      (busy),
        .gnt_id    (gnt_id),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_finish (tx_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 ns after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b1;
        req       = '0;
        tx_finish = 1'b0;
        r_tx_en   = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    // Tick until tx_start is observed, at most max_cyc cycles.
    task automatic wait_start(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            tick();
            if (tx_start === 1'b1) ok = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        bit saw_ack;
        do_reset();
        vectors++;
        if ({busy, tx_start, ack, ack_err, gnt_id, tx_data} !== {1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b start=%b ack=%b err=%b gnt=%0d data=%h, want all zero",
                     busy, tx_start, ack, ack_err, gnt_id, tx_data);
        end
        // Reset in the middle of a transfer to requester 2.
        req      = 4'b0100;
        req_data = 32'h44_C3_22_11;
        tick();          // START
        tick();          // WAIT
        vectors++;
        if (busy !== 1'b1 || gnt_id !== 3'd2) begin
            miscompares++;
            $display("FAIL reset_pre_wait: busy=%b gnt=%0d, want busy=1 gnt=2", busy, gnt_id);
        end
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();
        vectors++;
        if (busy !== 1'b0 || tx_data !== 8'h00 || gnt_id !== 3'd0 || ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_wait: busy=%b data=%h gnt=%0d ack=%b, want 0/00/0/0000",
                     busy, tx_data, gnt_id, ack);
        end
        rst_n     = 1'b0;
        tx_finish = 1'b1;
        saw_ack   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack !== 4'b0000 || busy !== 1'b0) saw_ack = 1'b1;
        end
        tx_finish = 1'b0;
        vectors++;
        if (saw_ack) begin
            miscompares++;
            $display("FAIL reset_no_ack: activity seen after reset abort, want none");
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        bit ok;
        do_reset();
        req_data = 32'h44_A5_22_11;
        req      = 4'b0100;
        tick();
        vectors++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || gnt_id !== 3'd2 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_start: start=%b data=%h gnt=%0d busy=%b, want 1/a5/2/1",
                     tx_start, tx_data, gnt_id, busy);
        end
        req_data = 32'h44_5A_22_11;   // must not disturb the captured byte
        ok = 1'b1;
        for (int i = 0; i < 49; i++) begin
            tick();
            if (tx_start !== 1'b0 || ack !== 4'b0000) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_wait: extra start or early ack during wait");
        end
        tx_finish = 1'b1;
        tick();
        tx_finish = 1'b0;
        vectors++;
        if (ack !== 4'b0100 || ack_err !== 1'b0 || tx_data !== 8'hA5 || gnt_id !== 3'd2) begin
            miscompares++;
            $display("FAIL single_ack: ack=%b err=%b data=%h gnt=%0d, want 0100/0/a5/2",
                     ack, ack_err, tx_data, gnt_id);
        end
        req = 4'b0000;
        tick();
        vectors++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_after: ack=%b busy=%b, want 0000/0", ack, busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        bit ok;
        logic [2:0] exp_id;
        do_reset();
        req_data = 32'h33_22_11_00;
        req      = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_id = 3'(n % 4);
            wait_start(10, ok);
            vectors++;
            if (!ok || gnt_id !== exp_id || tx_data !== {4'h0, 1'b0, exp_id} * 8'h11) begin
                miscompares++;
                $display("FAIL rr_grant%0d: started=%b gnt=%0d data=%h, want gnt=%0d", n, ok, gnt_id, tx_data, exp_id);
            end
            for (int i = 0; i < 9; i++) tick();
            tx_finish = 1'b1;
            tick();
            tx_finish = 1'b0;
            vectors++;
            if (ack !== (4'b0001 << exp_id) || ack_err !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_ack%0d: ack=%b err=%b, want %b/0", n, ack, ack_err, 4'b0001 << exp_id);
            end
        end
        req = 4'b0000;
        tick();
        vectors++;
        if (ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL rr_single_pulse: ack=%b, want 0000", ack);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pointer_wrap();
        bit ok;
        logic [2:0] exp_seq [3];
        exp_seq[0] = 3'd3;
        exp_seq[1] = 3'd0;
        exp_seq[2] = 3'd3;
        do_reset();
        req_data = 32'hD3_C2_B1_A0;
        req      = 4'b1000;
        for (int n = 0; n < 3; n++) begin
            wait_start(10, ok);
            vectors++;
            if (!ok || gnt_id !== exp_seq[n]) begin
                miscompares++;
                $display("FAIL wrap_grant%0d: started=%b gnt=%0d, want %0d", n, ok, gnt_id, exp_seq[n]);
            end
            req = 4'b1001;
            tick();
            tx_finish = 1'b1;
            tick();
            tx_finish = 1'b0;
        end
        req = 4'b0000;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        bit ok;
        int cnt;
        do_reset();
        req_data = 32'h00_00_00_7E;
        req      = 4'b0001;
        wait_start(10, ok);
        cnt = 0;
        while (ok && ack === 4'b0000 && cnt < 200) begin
            tick();
            cnt++;
        end
        vectors++;
        if (!ok || cnt != TIMEOUT_CYC || ack !== 4'b0001 || ack_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_ack: started=%b cycles=%0d ack=%b err=%b, want 100/0001/1",
                     ok, cnt, ack, ack_err);
        end
        req = 4'b0000;
        tick();
        vectors++;
        if (busy !== 1'b0 || ack_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_idle: busy=%b err=%b, want 0/0", busy, ack_err);
        end
        // Completion on the watchdog's final WAIT cycle wins.
        req = 4'b0001;
        wait_start(10, ok);
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
        vectors++;
        if (!ok || ack !== 4'b0000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_edge_pre: ack=%b busy=%b, want 0000/1", ack, busy);
        end
        tx_finish = 1'b1;
        tick();
        tx_finish = 1'b0;
        vectors++;
        if (ack !== 4'b0001 || ack_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_edge_ack: ack=%b err=%b, want 0001/0", ack, ack_err);
        end
        req = 4'b0000;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_finish_level();
        do_reset();
        req_data  = 32'h00_00_00_3C;
        tx_finish = 1'b1;             // held high throughout
        req       = 4'b0001;
        tick();                       // START: finish ignored here
        tick();                       // WAIT: finish seen
        vectors++;
        if (ack !== 4'b0000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL level_start_ignored: ack=%b busy=%b, want 0000/1", ack, busy);
        end
        tick();                       // DONE
        vectors++;
        if (ack !== 4'b0001 || ack_err !== 1'b0) begin
            miscompares++;
            $display("FAIL level_ack: ack=%b err=%b, want 0001/0", ack, ack_err);
        end
        req = 4'b0000;
        tick();
        tick();
        vectors++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL level_no_spurious: ack=%b busy=%b, want 0000/0", ack, busy);
        end
        tx_finish = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_enable();
        bit ok;
        do_reset();
        r_tx_en  = 1'b0;
        req_data = 32'h00_00_E1_00;
        req      = 4'b0010;
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (tx_start !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL enable_blocked: grant issued while disabled");
        end
        r_tx_en = 1'b1;
        tick();
        vectors++;
        if (tx_start !== 1'b1 || gnt_id !== 3'd1 || tx_data !== 8'hE1) begin
            miscompares++;
            $display("FAIL enable_start: start=%b gnt=%0d data=%h, want 1/1/e1", tx_start, gnt_id, tx_data);
        end
        tick();
        r_tx_en = 1'b0;               // drop enable mid-WAIT
        for (int i = 0; i < 5; i++) tick();
        tx_finish = 1'b1;
        tick();
        tx_finish = 1'b0;
        vectors++;
        if (ack !== 4'b0010 || ack_err !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_inflight_ack: ack=%b err=%b, want 0010/0", ack, ack_err);
        end
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_start !== 1'b0) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL enable_regrant: new grant while disabled after ack");
        end
        req     = 4'b0000;
        r_tx_en = 1'b1;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        r_tx_en     = 1'b1;
        req         = '0;
        req_data    = '0;
        tx_finish   = 1'b0;

        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_timeout();
        test_finish_level();
        test_enable();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
